// File: rtl/frame_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_scan_ctrl: walks an H_RES x V_RES frame, clearing or scanning it    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module frame_scan_ctrl #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int XW        = 10,
  parameter int YW        = 9,
  parameter int COLOR_W   = 1,
  parameter int COL_MAJOR = 1,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               replay,
  input  logic               stall,
  input  logic [COLOR_W-1:0] fill_color,
  output logic [XW-1:0]      addr_x,
  output logic [YW-1:0]      addr_y,
  output logic [XW-1:0]      px_x,
  output logic [YW-1:0]      px_y,
  output logic               px_valid,
  output logic               draw_fill,
  output logic [COLOR_W-1:0] fill_out,
  output logic               frame_done
);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_SCAN = 1'b1} state_t;

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  state_t               state_q, state_d;
  logic [XW-1:0]        addr_x_q, addr_x_d;
  logic [YW-1:0]        addr_y_q, addr_y_d;
  logic [COLOR_W-1:0]   fill_q, fill_d;
  logic [XW-1:0]        pipe_x_q [RD_LAT];
  logic [XW-1:0]        pipe_x_d [RD_LAT];
  logic [YW-1:0]        pipe_y_q [RD_LAT];
  logic [YW-1:0]        pipe_y_d [RD_LAT];
  logic [RD_LAT-1:0]    pipe_v_q, pipe_v_d;

  logic                 advance, x_last, y_last, at_last, at_origin;
  logic [XW-1:0]        nxt_x;
  logic [YW-1:0]        nxt_y;

  always_comb begin
    advance   = ~stall;
    x_last    = (addr_x_q == X_LAST);
    y_last    = (addr_y_q == Y_LAST);
    at_last   = x_last & y_last;
    at_origin = (addr_x_q == '0) && (addr_y_q == '0);

    nxt_x = addr_x_q;
    nxt_y = addr_y_q;
    if (COL_MAJOR != 0) begin
      if (y_last) begin
        nxt_y = '0;
        nxt_x = x_last ? '0 : addr_x_q + 1'b1;
      end else begin
        nxt_y = addr_y_q + 1'b1;
      end
    end else begin
      if (x_last) begin
        nxt_x = '0;
        nxt_y = y_last ? '0 : addr_y_q + 1'b1;
      end else begin
        nxt_x = addr_x_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_x_d = addr_x_q;
    addr_y_d = addr_y_q;
    fill_d   = fill_q;
    pipe_x_d = pipe_x_q;
    pipe_y_d = pipe_y_q;
    pipe_v_d = pipe_v_q;

    if (advance) begin
      case (state_q)
        ST_CLEAR: begin
          if (at_origin) fill_d = fill_color;
          addr_x_d = nxt_x;
          addr_y_d = nxt_y;
          pipe_v_d = '0;
          // A clear pass always runs to the last pixel before replay is honoured.
          if (at_last && replay) state_d = ST_SCAN;
        end
        default: begin
          if (!replay) begin
            state_d  = ST_CLEAR;
            addr_x_d = '0;
            addr_y_d = '0;
            pipe_v_d = '0;
          end else begin
            addr_x_d = nxt_x;
            addr_y_d = nxt_y;
            for (int i = RD_LAT - 1; i > 0; i--) begin
              pipe_x_d[i] = pipe_x_q[i-1];
              pipe_y_d[i] = pipe_y_q[i-1];
              pipe_v_d[i] = pipe_v_q[i-1];
            end
            pipe_x_d[0] = addr_x_q;
            pipe_y_d[0] = addr_y_q;
            pipe_v_d[0] = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      addr_x_q <= '0;
      addr_y_q <= '0;
      fill_q   <= '0;
      pipe_v_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_x_q[i] <= '0;
        pipe_y_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_x_q <= addr_x_d;
      addr_y_q <= addr_y_d;
      fill_q   <= fill_d;
      pipe_v_q <= pipe_v_d;
      pipe_x_q <= pipe_x_d;
      pipe_y_q <= pipe_y_d;
    end
  end

  always_comb begin
    addr_x    = addr_x_q;
    addr_y    = addr_y_q;
    fill_out  = fill_q;
    draw_fill = (state_q == ST_CLEAR);
    if (state_q == ST_CLEAR) begin
      px_x       = addr_x_q;
      px_y       = addr_y_q;
      px_valid   = advance;
      frame_done = advance & at_last;
    end else begin
      px_x       = pipe_x_q[RD_LAT-1];
      px_y       = pipe_y_q[RD_LAT-1];
      px_valid   = advance & pipe_v_q[RD_LAT-1];
      // An aborting cycle is not an advance of the last address.
      frame_done = advance & at_last & replay;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_scan_ctrl: directed bench for frame_scan_ctrl (4x3, RD_LAT=2)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_frame_scan_ctrl;
  localparam int H = 4;
  localparam int V = 3;
  localparam int XW = 10;
  localparam int YW = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic replay = 1'b0;
  logic stall = 1'b0;
  logic fill_color = 1'b0;
  logic replay_rm = 1'b0;
  logic stall_rm = 1'b0;

  logic [XW-1:0] addr_x, px_x, addr_x_rm, px_x_rm;
  logic [YW-1:0] addr_y, px_y, addr_y_rm, px_y_rm;
  logic px_valid, draw_fill, fill_out, frame_done;
  logic px_valid_rm, draw_fill_rm, fill_out_rm, frame_done_rm;

  int n_cmp = 0;
  int n_err = 0;

  frame_scan_ctrl #(.H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .COLOR_W(1),
                    .COL_MAJOR(1), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .replay(replay), .stall(stall),
    .fill_color(fill_color), .addr_x(addr_x), .addr_y(addr_y),
    .px_x(px_x), .px_y(px_y), .px_valid(px_valid), .draw_fill(draw_fill),
    .fill_out(fill_out), .frame_done(frame_done));

  frame_scan_ctrl #(.H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .COLOR_W(1),
                    .COL_MAJOR(0), .RD_LAT(2)) dut_rm (
    .clk(clk), .reset(reset), .replay(replay_rm), .stall(stall_rm),
    .fill_color(fill_color), .addr_x(addr_x_rm), .addr_y(addr_y_rm),
    .px_x(px_x_rm), .px_y(px_y_rm), .px_valid(px_valid_rm),
    .draw_fill(draw_fill_rm), .fill_out(fill_out_rm),
    .frame_done(frame_done_rm));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input int x, input int y);
    chk({tag, ".addr_x"}, 32'(addr_x), x);
    chk({tag, ".addr_y"}, 32'(addr_y), y);
  endtask

  task automatic chk_px(input string tag, input int x, input int y, input int v, input int df);
    chk({tag, ".px_x"}, 32'(px_x), x);
    chk({tag, ".px_y"}, 32'(px_y), y);
    chk({tag, ".px_valid"}, 32'(px_valid), v);
    chk({tag, ".draw_fill"}, 32'(draw_fill), df);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #1;
    chk_addr("rst", 0, 0);
    chk_px("rst", 0, 0, 1, 1);
    chk("rst.frame_done", 32'(frame_done), 0);
    chk("rst.fill_out", 32'(fill_out), 0);
    stall = 1'b1;
    #1;
    chk("rst.px_valid_stall", 32'(px_valid), 0);
    stall = 1'b0;
    tick();
    reset = 1'b0;

    // Two clear frames; fill colour changes in the first, replay rises in the second
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 12; k++) begin
        if (f == 0 && k == 5) fill_color = 1'b1;
        if (f == 1 && k == 5) replay = 1'b1;
        #1;
        chk_addr("clr", k / V, k % V);
        chk_px("clr", k / V, k % V, 1, 1);
        chk("clr.frame_done", 32'(frame_done), (k == 11) ? 1 : 0);
        chk("clr.fill_out", 32'(fill_out), (f == 1 && k >= 1) ? 1 : 0);
        chk("rm.px_x", 32'(px_x_rm), k % H);
        chk("rm.px_y", 32'(px_y_rm), k / H);
        chk("rm.frame_done", 32'(frame_done_rm), (k == 11) ? 1 : 0);
        tick();
      end
    end

    // SCAN entry, stall at (1,1), abort at (2,1)
    for (int s = 0; s < 8; s++) begin
      if (s == 4) begin
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
          #1;
          chk_addr("stall", 1, 1);
          chk_px("stall", 0, 2, 0, 0);
          chk("stall.frame_done", 32'(frame_done), 0);
          tick();
        end
        stall = 1'b0;
      end
      if (s == 7) replay = 1'b0;
      #1;
      chk_addr("scan", s / V, s % V);
      chk("scan.draw_fill", 32'(draw_fill), 0);
      chk("scan.px_valid", 32'(px_valid), (s >= 2) ? 1 : 0);
      if (s >= 2) begin
        chk("scan.px_x", 32'(px_x), (s - 2) / V);
        chk("scan.px_y", 32'(px_y), (s - 2) % V);
      end
      tick();
    end
    #1;
    chk_addr("abort", 0, 0);
    chk_px("abort", 0, 0, 1, 1);

    // Full clear pass with replay held high, then SCAN across a frame wrap
    replay = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk_px("clr2", k / V, k % V, 1, 1);
      tick();
    end
    for (int s = 0; s < 13; s++) begin
      #1;
      chk_addr("scan2", (s % 12) / V, (s % 12) % V);
      chk("scan2.frame_done", 32'(frame_done), (s == 11) ? 1 : 0);
      chk("scan2.px_valid", 32'(px_valid), (s >= 2) ? 1 : 0);
      if (s >= 2) begin
        chk("scan2.px_x", 32'(px_x), ((s - 2) % 12) / V);
        chk("scan2.px_y", 32'(px_y), ((s - 2) % 12) % V);
      end
      tick();
    end

    // Asynchronous reset mid-SCAN takes effect without a clock edge
    reset = 1'b1;
    #1;
    chk_addr("arst", 0, 0);
    chk_px("arst", 0, 0, 1, 1);
    chk("arst.frame_done", 32'(frame_done), 0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
